vector_control_unit: RTL
========================

# vector_control_unit

Registered decode/sequencing unit for the vector processor's decode stage, successor to the single-cycle scalar control decoder. It decodes scalar data-processing, load/store, branch and halt instructions into the pipeline control bundle, and additionally sequences vector instructions over `BEATS = VLEN/LANES` issue beats. While a vector instruction is sequencing, it back-pressures fetch. It also flags illegal encodings instead of emitting don't-cares.

## Interface
- `LANES`, 4: datapath lanes per beat.
- `VLEN`, 16: vector length in elements; `VLEN % LANES == 0`, `BEATS = VLEN/LANES >= 1`.
- `BW`, `$clog2(BEATS)` (min 1): width of `beat_o`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid_i` in 1: decode-stage instruction present.
- `op_i` in 2: opcode class.
- `funct_i` in 6: function field.
- `rd_i` in 4: destination register.
- `vec_i` in 1: instruction is a vector instruction.
- `stall_i` in 1: downstream hazard stall; freezes unit.
- `ready_o` out 1: unit can accept an instruction this cycle.
- `stuck_o` out 1: hold fetch/PC (`!ready_o | halted`).
- `issue_valid_o` out 1: control bundle below is valid this cycle.
- `beat_o` out BW: beat index of current issue (0 for scalar).
- `vec_o` out 1: current issue is vector.
- `reg_write_o`, `mem_to_reg_o`, `mem_write_o`, `branch_o`, `alu_src_o`, `pc_src_o` out 1 each.
- `imm_src_o`, `reg_src_o`, `flag_write_o` out 2 each; `alu_ctrl_o` out 3.
- `illegal_o` out 1: one-cycle pulse, rejected encoding.
- `halted_o` out 1: sticky halt.

## Operation
- States: IDLE, ISSUE, HALT. `ready_o = (state==IDLE)`; accept = `instr_valid_i & ready_o & !stall_i`.
- Decode on accept:
  - `op=00`, data processing: `reg_write=1`; `alu_src=funct[5]`; `imm_src=00`.
  - `op=01`, `funct[0]=1` (LDR): `imm_src=01`, `alu_src=1`, `mem_to_reg=1`, `reg_write=1`.
  - `op=01`, `funct[0]=0` (STR): `reg_src=10`, `imm_src=01`, `alu_src=1`, `mem_write=1`.
  - `op=10` (B): `reg_src=01`, `imm_src=10`, `alu_src=1`, `branch=1`.
  - `op=11`: go to HALT; no issue.
- ALU control for data processing, keyed on `funct[4:1]`: 0100→000 ADD, 0010→001 SUB, 0000→010 AND, 1100→011 ORR, 0001→100 MUL, 0011→101 AVG, 0101→110 THR, 0111→111 SHL. Non-DP instructions use 000.
- Flags: `flag_write[1]=funct[0]`; `flag_write[0]=funct[0] & (ADD|SUB)`. Both are 0 for non-DP instructions.
- `pc_src = (rd==4'hF & reg_write) | branch`.
- Illegal, which pulses `illegal_o`, issues nothing (all controls 0) and stays IDLE:
  - unmapped DP `funct[4:1]`;
  - `vec_i` with `op=10`;
  - `vec_i` with `rd==4'hF`.
- Scalar instructions issue one beat, with `beat_o=0` and `vec_o=0`.
- Vector instructions:
  - Beat 0 issues on accept. If `BEATS>1`, go to ISSUE with beat counter 1.
  - In ISSUE, each non-stalled cycle issues the next beat with the same control bundle and `beat_o` = counter.
  - Return to IDLE after beat `BEATS-1`.
  - `flag_write_o` is nonzero only on the last beat; `pc_src_o` is always 0.
- HALT is terminal until `rst`: `halted_o=1`, `ready_o=0`, `issue_valid_o=0`.

## Timing
- All outputs are registered.
- Accept at edge t: beat 0 bundle is visible in cycle t+1. With no stall, beat k is visible in cycle t+1+k.
- `ready_o` is low for cycles t+1 … t+BEATS-1 and high again at cycle t+BEATS. With `BEATS=1`, vector timing equals scalar timing.
- `issue_valid_o` is high for exactly one cycle per beat. When nothing is accepted or issued, it is 0 and all control outputs are 0.
- `stall_i=1`: state, beat counter and every output hold their value; the hold includes `issue_valid_o` and `illegal_o`.
- Halt opcode accepted at edge t: `halted_o=1` and `stuck_o=1` from cycle t+1.
- Reset: state IDLE, counter 0, all outputs 0 except `ready_o=1`.
  - Reset mid-vector aborts the remaining beats; no flag write is issued.
  - Reset has priority over `stall_i`.

## Test plan
- Scalar ADD-immediate with S (`op=00`, `funct=101001`, `rd=3`) → next cycle: `issue_valid=1`, `alu_src=1`, `reg_write=1`, `alu_ctrl=000`, `flag_write=11`, `pc_src=0`, `ready_o=1`.
- Vector MUL with S (`vec=1`, `funct=000011`), `LANES=4`, `VLEN=16`:
  - `beat_o` = 0,1,2,3 on four consecutive cycles;
  - `flag_write` = 00,00,00,10;
  - `ready_o`/`stuck_o` = 0/1 for three cycles.
- Same vector op with `stall_i=1` for 2 cycles during beat 1 → beat 1 bundle held 3 cycles, then beats 2 and 3; no beat skipped or duplicated beyond the hold.
- Scalar `op=00`, `funct=0x`, `rd=15`, register form → `reg_write=1`, `pc_src=1`. The same instruction with `vec=1` → `illegal_o` one-cycle pulse, `issue_valid=0`.
- Undefined `funct[4:1]=1111` → `illegal_o` pulse, all controls 0. B (`op=10`) → `branch=1`, `pc_src=1`, `reg_src=01`, `imm_src=10`.
- Halt (`op=11`) → `halted_o=1` from the next cycle, and later instructions are ignored. Assert `rst` during a vector's beat 2 → next cycle IDLE, all outputs 0, `ready_o=1`, no flag write observed.

Source files
------------

// File: rtl/vector_control_unit.sv
// Registered decode/sequencing unit: decodes scalar instructions into the pipeline
// control bundle and replays vector instructions over VLEN/LANES issue beats.
module vector_control_unit #(
    parameter int LANES = 4,
    parameter int VLEN  = 16,
    localparam int BEATS = VLEN / LANES,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid_i,
    input  logic [1:0]    op_i,
    input  logic [5:0]    funct_i,
    input  logic [3:0]    rd_i,
    input  logic          vec_i,
    input  logic          stall_i,
    output logic          ready_o,
    output logic          stuck_o,
    output logic          issue_valid_o,
    output logic [BW-1:0] beat_o,
    output logic          vec_o,
    output logic          reg_write_o,
    output logic          mem_to_reg_o,
    output logic          mem_write_o,
    output logic          branch_o,
    output logic          alu_src_o,
    output logic          pc_src_o,
    output logic [1:0]    imm_src_o,
    output logic [1:0]    reg_src_o,
    output logic [1:0]    flag_write_o,
    output logic [2:0]    alu_ctrl_o,
    output logic          illegal_o,
    output logic          halted_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       pc_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [1:0] flag_write;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_AVG = 3'b101;
    localparam logic [2:0] ALU_THR = 3'b110;
    localparam logic [2:0] ALU_SHL = 3'b111;

    state_t        state, state_n;
    logic [BW-1:0] cnt, cnt_n;
    ctrl_t         saved, saved_n;
    ctrl_t         ctrl_q, ctrl_n;
    logic          issue_q, issue_n;
    logic [BW-1:0] beat_q, beat_n;
    logic          vec_q, vec_n;
    logic          illegal_q, illegal_n;

    ctrl_t         dec;
    logic [2:0]    dp_alu;
    logic          dp_ok;
    logic          dec_illegal;
    logic          dec_halt;

    // Pure instruction decode; only consumed when an instruction is accepted.
    always_comb begin
        dec    = '0;
        dp_ok  = 1'b1;
        dp_alu = ALU_ADD;
        case (funct_i[4:1])
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b0001: dp_alu = ALU_MUL;
            4'b0011: dp_alu = ALU_AVG;
            4'b0101: dp_alu = ALU_THR;
            4'b0111: dp_alu = ALU_SHL;
            default: dp_ok  = 1'b0;
        endcase

        case (op_i)
            2'b00: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = funct_i[5];
                dec.alu_ctrl   = dp_alu;
                dec.flag_write = {funct_i[0],
                                  funct_i[0] & ((dp_alu == ALU_ADD) | (dp_alu == ALU_SUB))};
            end
            2'b01: begin
                dec.imm_src = 2'b01;
                dec.alu_src = 1'b1;
                if (funct_i[0]) begin
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                end else begin
                    dec.reg_src   = 2'b10;
                    dec.mem_write = 1'b1;
                end
            end
            2'b10: begin
                dec.reg_src = 2'b01;
                dec.imm_src = 2'b10;
                dec.alu_src = 1'b1;
                dec.branch  = 1'b1;
            end
            default: ;
        endcase
        dec.pc_src = ((rd_i == 4'hF) & dec.reg_write) | dec.branch;

        dec_illegal = ((op_i == 2'b00) & ~dp_ok)
                    | (vec_i & (op_i == 2'b10))
                    | (vec_i & (rd_i == 4'hF));
        dec_halt    = (op_i == 2'b11);
    end

    // Next-state and next-output logic; a stall freezes every register.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        saved_n   = saved;
        ctrl_n    = '0;
        issue_n   = 1'b0;
        beat_n    = '0;
        vec_n     = 1'b0;
        illegal_n = 1'b0;

        if (stall_i) begin
            ctrl_n    = ctrl_q;
            issue_n   = issue_q;
            beat_n    = beat_q;
            vec_n     = vec_q;
            illegal_n = illegal_q;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid_i) begin
                        if (dec_illegal) begin
                            illegal_n = 1'b1;
                        end else if (dec_halt) begin
                            state_n = HALT;
                        end else begin
                            issue_n = 1'b1;
                            ctrl_n  = dec;
                            if (vec_i) begin
                                vec_n         = 1'b1;
                                ctrl_n.pc_src = 1'b0;
                                // Flags are written once, on the final beat only.
                                if (BEATS > 1) begin
                                    saved_n           = dec;
                                    saved_n.pc_src    = 1'b0;
                                    ctrl_n.flag_write = 2'b00;
                                    cnt_n             = BW'(1);
                                    state_n           = ISSUE;
                                end
                            end
                        end
                    end
                end
                ISSUE: begin
                    issue_n = 1'b1;
                    vec_n   = 1'b1;
                    beat_n  = cnt;
                    ctrl_n  = saved;
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        ctrl_n.flag_write = 2'b00;
                        cnt_n             = cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            saved     <= '0;
            ctrl_q    <= '0;
            issue_q   <= 1'b0;
            beat_q    <= '0;
            vec_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            saved     <= saved_n;
            ctrl_q    <= ctrl_n;
            issue_q   <= issue_n;
            beat_q    <= beat_n;
            vec_q     <= vec_n;
            illegal_q <= illegal_n;
        end
    end

    assign ready_o       = (state == IDLE);
    assign halted_o      = (state == HALT);
    assign stuck_o       = ~ready_o | halted_o;
    assign issue_valid_o = issue_q;
    assign beat_o        = beat_q;
    assign vec_o         = vec_q;
    assign illegal_o     = illegal_q;
    assign reg_write_o   = ctrl_q.reg_write;
    assign mem_to_reg_o  = ctrl_q.mem_to_reg;
    assign mem_write_o   = ctrl_q.mem_write;
    assign branch_o      = ctrl_q.branch;
    assign alu_src_o     = ctrl_q.alu_src;
    assign pc_src_o      = ctrl_q.pc_src;
    assign imm_src_o     = ctrl_q.imm_src;
    assign reg_src_o     = ctrl_q.reg_src;
    assign flag_write_o  = ctrl_q.flag_write;
    assign alu_ctrl_o    = ctrl_q.alu_ctrl;

endmodule
